// File: rtl/idct_vec_rot_pkg.sv
// Shared constants, FSM state type and frame-length helper for the IDCT
// vector-rotation stage.
package idct_vec_rot_pkg;

  localparam int BUF_DEPTH  = 2048;
  localparam int ADDR_W     = 11;
  localparam int COEF_SHIFT = 16;

  localparam logic [11:0] FFTPTS_32   = 12'd32;
  localparam logic [11:0] FFTPTS_64   = 12'd64;
  localparam logic [11:0] FFTPTS_128  = 12'd128;
  localparam logic [11:0] FFTPTS_256  = 12'd256;
  localparam logic [11:0] FFTPTS_512  = 12'd512;
  localparam logic [11:0] FFTPTS_1024 = 12'd1024;
  localparam logic [11:0] FFTPTS_2048 = 12'd2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Any frame length outside the supported set runs as the largest frame.
  function automatic logic [11:0] legalFftpts(input logic [11:0] n);
    case (n)
      FFTPTS_32, FFTPTS_64, FFTPTS_128, FFTPTS_256,
      FFTPTS_512, FFTPTS_1024, FFTPTS_2048: return n;
      default:                              return FFTPTS_2048;
    endcase
  endfunction

endpackage

// File: rtl/idct_vec_rot_buf.sv
// Frame buffer: one write port, two registered read ports, built as two
// mirrored simple-dual-port RAMs that always receive the same writes.
module idct_vec_rot_buf
  import idct_vec_rot_pkg::*;
#(
  parameter int wIn = 16
) (
  input  logic                  clk,
  input  logic                  i_wrEn,
  input  logic [ADDR_W-1:0]     i_wrAddr,
  input  logic signed [wIn-1:0] i_wrData,
  input  logic [ADDR_W-1:0]     i_rdAddrA,
  input  logic [ADDR_W-1:0]     i_rdAddrB,
  output logic signed [wIn-1:0] o_rdDataA,
  output logic signed [wIn-1:0] o_rdDataB
);

  logic signed [wIn-1:0] r_ramA [BUF_DEPTH];
  logic signed [wIn-1:0] r_ramB [BUF_DEPTH];
  logic signed [wIn-1:0] r_rdA;
  logic signed [wIn-1:0] r_rdB;

  always_ff @(posedge clk) begin
    if (i_wrEn) r_ramA[i_wrAddr] <= i_wrData;
    r_rdA <= r_ramA[i_rdAddrA];
  end

  always_ff @(posedge clk) begin
    if (i_wrEn) r_ramB[i_wrAddr] <= i_wrData;
    r_rdB <= r_ramB[i_rdAddrB];
  end

  assign o_rdDataA = r_rdA;
  assign o_rdDataB = r_rdB;

endmodule

// File: rtl/idct_vec_rot.sv
// Pre-IFFT vector rotation for the IDCT: buffers one frame of real D(k) and
// streams F(k) = (D(k) - j*D(N+2-k)) * (cos + j*sin) into the IFFT core.
module idct_vec_rot
  import idct_vec_rot_pkg::*;
#(
  parameter int wIn   = 16,
  parameter int wCoef = 18,
  parameter int wOut  = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [wIn-1:0]  sink_data,
  input  logic [11:0]            fftpts_in,
  output logic                   sink_ready,
  output logic                   coeff_valid,
  output logic [11:0]            coeff_fftpts,
  input  logic [wCoef-1:0]       coeff_cos,
  input  logic [wCoef-1:0]       coeff_sin,
  output logic                   source_valid,
  output logic                   source_sop,
  output logic                   source_eop,
  output logic signed [wOut-1:0] source_real,
  output logic signed [wOut-1:0] source_imag,
  output logic                   frame_err
);

  // Two guard bits above a single product so the sum/difference never wraps.
  localparam int PW = wIn + wCoef + 2;
  localparam logic signed [PW-1:0] SAT_HI = PW'((1 <<< (wOut - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [wOut-1:0] satShift(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] sh;
    sh = v >>> COEF_SHIFT;
    if (sh > SAT_HI)      return SAT_HI[wOut-1:0];
    else if (sh < SAT_LO) return SAT_LO[wOut-1:0];
    else                  return sh[wOut-1:0];
  endfunction

  state_t                r_state;
  logic [ADDR_W-1:0]     r_wcnt;
  logic [ADDR_W-1:0]     r_rcnt;
  logic [11:0]           r_n;
  logic [ADDR_W-1:0]     w_last;
  logic [ADDR_W-1:0]     w_rdAddrB;
  logic [ADDR_W-1:0]     w_wrAddr;
  logic                  w_wrEn;
  logic signed [wIn-1:0] w_rdA;
  logic signed [wIn-1:0] w_rdB;

  logic                  r_v1, r_sop1, r_eop1, r_zb1;
  logic                  r_v2, r_sop2, r_eop2;
  logic signed [PW-1:0]  r_ac, r_bs, r_as, r_bc;
  logic signed [PW-1:0]  w_a, w_b, w_c, w_s;

  assign w_last       = ADDR_W'(r_n - 12'd1);
  assign w_rdAddrB    = ADDR_W'(r_n - {1'b0, r_rcnt}) & w_last;
  assign w_wrEn       = sink_valid &&
                        ((r_state == ST_IDLE && sink_sop) || r_state == ST_WRITE);
  assign w_wrAddr     = sink_sop ? '0 : r_wcnt;
  assign coeff_fftpts = r_n;

  idct_vec_rot_buf #(.wIn(wIn)) u_buf (
    .clk       (clk),
    .i_wrEn    (w_wrEn),
    .i_wrAddr  (w_wrAddr),
    .i_wrData  (sink_data),
    .i_rdAddrA (r_rcnt),
    .i_rdAddrB (w_rdAddrB),
    .o_rdDataA (w_rdA),
    .o_rdDataB (w_rdB)
  );

  // A sop always restarts the frame at index 0, even in the middle of WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_n         <= FFTPTS_2048;
      sink_ready  <= 1'b1;
      coeff_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sink_valid) begin
            if (sink_sop) begin
              r_n       <= legalFftpts(fftpts_in);
              r_wcnt    <= ADDR_W'(1);
              r_state   <= ST_WRITE;
              frame_err <= sink_eop;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (sink_valid) begin
            if (sink_sop) begin
              r_n       <= legalFftpts(fftpts_in);
              r_wcnt    <= ADDR_W'(1);
              frame_err <= 1'b1;
            end else if (r_wcnt == w_last) begin
              frame_err   <= !sink_eop;
              r_state     <= ST_READ;
              r_rcnt      <= '0;
              sink_ready  <= 1'b0;
              coeff_valid <= 1'b1;
            end else begin
              frame_err <= sink_eop;
              r_wcnt    <= r_wcnt + 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_rcnt == w_last) begin
            r_state     <= ST_GAP;
            r_rcnt      <= '0;
            coeff_valid <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        ST_GAP: begin
          r_state    <= ST_IDLE;
          sink_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_a = PW'(w_rdA);
  assign w_b = r_zb1 ? '0 : PW'(w_rdB);
  assign w_c = PW'({1'b0, coeff_cos});
  assign w_s = PW'({1'b0, coeff_sin});

  // Read data and generator coefficients line up one cycle after read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1         <= 1'b0;
      r_sop1       <= 1'b0;
      r_eop1       <= 1'b0;
      r_zb1        <= 1'b0;
      r_v2         <= 1'b0;
      r_sop2       <= 1'b0;
      r_eop2       <= 1'b0;
      r_ac         <= '0;
      r_bs         <= '0;
      r_as         <= '0;
      r_bc         <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
    end else begin
      r_v1         <= coeff_valid;
      r_sop1       <= coeff_valid && (r_rcnt == '0);
      r_eop1       <= coeff_valid && (r_rcnt == w_last);
      r_zb1        <= (r_rcnt == '0);
      r_v2         <= r_v1;
      r_sop2       <= r_sop1;
      r_eop2       <= r_eop1;
      r_ac         <= w_a * w_c;
      r_bs         <= w_b * w_s;
      r_as         <= w_a * w_s;
      r_bc         <= w_b * w_c;
      source_valid <= r_v2;
      source_sop   <= r_sop2;
      source_eop   <= r_eop2;
      source_real  <= r_v2 ? satShift(r_ac + r_bs) : '0;
      source_imag  <= r_v2 ? satShift(r_as - r_bc) : '0;
    end
  end

endmodule

// File: tb/tb_idct_vec_rot.sv
// Self-checking bench for idct_vec_rot: a coefficient-generator stand-in plus
// an arithmetic model of F(k) checked against every valid output cycle.
`timescale 1ns/1ps
module tb_idct_vec_rot;

  localparam int     wIn    = 16;
  localparam int     wCoef  = 18;
  localparam int     wOut   = 18;
  localparam longint SAT_HI = 131071;
  localparam longint SAT_LO = -131072;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   sink_valid, sink_sop, sink_eop;
  logic signed [wIn-1:0]  sink_data;
  logic [11:0]            fftpts_in;
  logic                   sink_ready, coeff_valid;
  logic [11:0]            coeff_fftpts;
  logic [wCoef-1:0]       coeff_cos, coeff_sin;
  logic                   source_valid, source_sop, source_eop;
  logic signed [wOut-1:0] source_real, source_imag;
  logic                   frame_err;

  typedef struct { longint re; longint im; bit sop; bit eop; } exp_t;
  typedef struct { int data; bit sop; bit eop; } sample_t;

  exp_t    expQ[$];
  sample_t stimQ[$];
  int      dModel [0:2048];
  longint  capRe [0:2047];
  longint  capIm [0:2047];
  int      capN = 0;
  int      nCmp = 0;
  int      nBad = 0;
  int      errCnt = 0;
  int      lowRun = 0;
  int      lastLowRun = 0;
  int      genMode = 0;
  int      genAddr = 0;
  longint  cyc = 0;
  longint  cvRiseCyc = 0;
  bit      prevValid = 0, prevEop = 0, prevCv = 0;

  idct_vec_rot #(.wIn(wIn), .wCoef(wCoef), .wOut(wOut)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_data(sink_data), .fftpts_in(fftpts_in), .sink_ready(sink_ready),
    .coeff_valid(coeff_valid), .coeff_fftpts(coeff_fftpts),
    .coeff_cos(coeff_cos), .coeff_sin(coeff_sin),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint genCos(input int mode, input int k);
    case (mode)
      0:       return 65536;
      1:       return (k == 0) ? 92682 : 40000 + k * 300;
      2:       return 65536;
      3:       return 262143;
      default: return (k * 2749 + 1234) % 262144;
    endcase
  endfunction

  function automatic longint genSin(input int mode, input int k);
    case (mode)
      0:       return 0;
      1:       return (k == 0) ? 0 : 20000 + k * 500;
      2:       return 65536;
      3:       return 262143;
      default: return (k * 7919 + 555) % 262144;
    endcase
  endfunction

  function automatic longint satW(input longint v);
    if (v > SAT_HI) return SAT_HI;
    if (v < SAT_LO) return SAT_LO;
    return v;
  endfunction

  // Generator stand-in: one-cycle latency, address returns to 0 when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      genAddr   <= 0;
      coeff_cos <= '0;
      coeff_sin <= '0;
    end else if (coeff_valid) begin
      coeff_cos <= wCoef'(genCos(genMode, genAddr));
      coeff_sin <= wCoef'(genSin(genMode, genAddr));
      genAddr   <= genAddr + 1;
    end else begin
      genAddr <= 0;
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // F(k) for k = i+1, with D(N+1) taken as zero.
  task automatic modelFrame(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      longint a, b, c, s;
      exp_t   e;
      a = dModel[i + 1];
      b = (i == 0) ? 0 : dModel[n + 1 - i];
      c = genCos(mode, i);
      s = genSin(mode, i);
      e.re  = satW((a * c + b * s) >>> 16);
      e.im  = satW((a * s - b * c) >>> 16);
      e.sop = (i == 0);
      e.eop = (i == n - 1);
      expQ.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 0;
      prevEop   = 0;
      prevCv    = 0;
      lowRun    = 0;
    end else begin
      if (frame_err) errCnt++;
      if (coeff_valid && !prevCv) cvRiseCyc = cyc;
      prevCv = coeff_valid;
      if (!sink_ready) lowRun++;
      else if (lowRun > 0) begin
        lastLowRun = lowRun;
        lowRun     = 0;
      end
      if (prevValid && !prevEop) checkOutput("valid_contiguous", source_valid, 1);
      if (source_valid) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("[TB] FAIL unexpected_valid: got source_valid=1, expected no pending output");
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("real", source_real, e.re);
          checkOutput("imag", source_imag, e.im);
          checkOutput("sop", source_sop, e.sop);
          checkOutput("eop", source_eop, e.eop);
          if (e.sop) begin
            capN = 0;
            checkOutput("latency", cyc - cvRiseCyc, 3);
          end
          if (capN < 2048) begin
            capRe[capN] = source_real;
            capIm[capN] = source_imag;
            capN++;
          end
        end
      end
      prevValid = source_valid;
      prevEop   = source_eop;
    end
  end

  task automatic queueFrame(input int n, input int eopAt, input int junk);
    sample_t smp;
    for (int k = 1; k <= junk; k++) begin
      smp.data = -999; smp.sop = (k == 1); smp.eop = 0;
      stimQ.push_back(smp);
    end
    for (int k = 1; k <= n; k++) begin
      smp.data = dModel[k]; smp.sop = (k == 1); smp.eop = (k == eopAt);
      stimQ.push_back(smp);
    end
  endtask

  task automatic applyStimulus(input int n, input int gapPct);
    sample_t smp;
    while (stimQ.size() > 0) begin
      @(posedge clk); #1;
      if (gapPct > 0 && $urandom_range(99) < gapPct) begin
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
      end else begin
        smp = stimQ.pop_front();
        sink_valid = 1;
        sink_sop   = smp.sop;
        sink_eop   = smp.eop;
        sink_data  = wIn'(smp.data);
        fftpts_in  = 12'(n);
      end
    end
    @(posedge clk); #1;
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
  endtask

  task automatic waitFrameDone();
    int t = 0;
    while ((expQ.size() != 0 || source_valid) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    nCmp++;
    if (t >= 6000) begin
      nBad++;
      $display("[TB] FAIL frame_timeout: got %0d outputs pending, expected 0", expQ.size());
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic runFrame(input int n, input int mode, input int gapPct,
                          input int eopAt, input int junk, input int expErr);
    int errBase;
    genMode = mode;
    modelFrame(n, mode);
    errBase = errCnt;
    queueFrame(n, eopAt, junk);
    applyStimulus(n, gapPct);
    waitFrameDone();
    checkOutput("frame_err_count", errCnt - errBase, expErr);
    checkOutput("coeff_fftpts", coeff_fftpts, n);
    checkOutput("ready_low_cycles", lastLowRun, n + 1);
  endtask

  initial begin
    int t;
    sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_data = '0; fftpts_in = 12'd32;
    rst_n = 0;
    #12;
    checkOutput("rst_sink_ready", sink_ready, 1);
    checkOutput("rst_coeff_valid", coeff_valid, 0);
    checkOutput("rst_coeff_fftpts", coeff_fftpts, 2048);
    checkOutput("rst_source_valid", source_valid, 0);
    checkOutput("rst_source_real", source_real, 0);
    checkOutput("rst_source_imag", source_imag, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    #10 rst_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] N=32 ramp, unit cosine");
    for (int k = 1; k <= 2048; k++) dModel[k] = (k <= 32) ? k : 0;
    runFrame(32, 0, 0, 32, 0, 0);
    checkOutput("ramp_re0", capRe[0], 1);
    checkOutput("ramp_im0", capIm[0], 0);
    checkOutput("ramp_re1", capRe[1], 2);
    checkOutput("ramp_im1", capIm[1], -32);
    checkOutput("ramp_im31", capIm[31], -2);

    $display("[TB] N=64 impulse");
    for (int k = 1; k <= 2048; k++) dModel[k] = 0;
    dModel[1] = 1000;
    runFrame(64, 1, 0, 64, 0, 0);
    checkOutput("imp_re0", capRe[0], 1414);
    checkOutput("imp_im0", capIm[0], 0);
    checkOutput("imp_re5", capRe[5], 0);

    $display("[TB] N=32 full scale");
    for (int k = 1; k <= 2048; k++) dModel[k] = 32767;
    runFrame(32, 2, 0, 32, 0, 0);
    checkOutput("fs_re1", capRe[1], 65534);
    checkOutput("fs_im1", capIm[1], 0);
    runFrame(32, 3, 0, 32, 0, 0);
    checkOutput("satp_re1", capRe[1], 131071);
    checkOutput("satp_re0", capRe[0], 131067);
    checkOutput("satp_im0", capIm[0], 131067);
    for (int k = 1; k <= 2048; k++) dModel[k] = -32768;
    runFrame(32, 3, 0, 32, 0, 0);
    checkOutput("satn_re1", capRe[1], -131072);
    checkOutput("satn_im1", capIm[1], 0);

    $display("[TB] N=128 random data, gapless then gapped");
    for (int k = 1; k <= 2048; k++) dModel[k] = int'($urandom_range(65535)) - 32768;
    runFrame(128, 4, 0, 128, 0, 0);
    runFrame(128, 4, 50, 128, 0, 0);

    $display("[TB] sop restart at sample 10");
    for (int k = 1; k <= 2048; k++) dModel[k] = 100 + k;
    runFrame(32, 0, 0, 32, 9, 1);
    checkOutput("restart_re0", capRe[0], 101);
    checkOutput("restart_im1", capIm[1], -132);

    $display("[TB] eop at wrong index");
    runFrame(32, 4, 0, 20, 0, 2);

    $display("[TB] reset during READ");
    genMode = 0;
    for (int k = 1; k <= 2048; k++) dModel[k] = k;
    modelFrame(32, 0);
    queueFrame(32, 32, 0);
    applyStimulus(32, 0);
    t = 0;
    while (!coeff_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_valid", source_valid, 1);
    #2 rst_n = 0;
    #1;
    checkOutput("arst_source_valid", source_valid, 0);
    checkOutput("arst_source_real", source_real, 0);
    checkOutput("arst_source_imag", source_imag, 0);
    checkOutput("arst_source_sop", source_sop, 0);
    checkOutput("arst_coeff_valid", coeff_valid, 0);
    checkOutput("arst_sink_ready", sink_ready, 1);
    expQ.delete();
    #20 rst_n = 1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 2048; k++) dModel[k] = 200 + k;
    runFrame(32, 0, 0, 32, 0, 0);
    checkOutput("post_reset_re0", capRe[0], 201);
    checkOutput("post_reset_im1", capIm[1], -232);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
